// File: rtl/bch_error_one_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bch_error_one_seq_pkg
//  Description : Shared BCH helpers for the sequenced single-error locator:
//                parameter set, geometry helpers and GF(2^m) arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
package bch_error_one_seq_pkg;

    // Widest field element handled by the helpers (m up to 16).
    localparam int c_gf_w = 17;

    typedef struct packed {
        int m;
        int t;
        int k;
        int data_bits;
    } bch_params_t;

    // BCH(15,7), t=2, seven data bits.
    localparam bch_params_t BCH_SANE = '{m: 4, t: 2, k: 7, data_bits: 7};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } one_seq_state_t;

    function automatic int bch_n(input int m);
        return (1 << m) - 1;
    endfunction

    function automatic int bch_windows(input int data_bits, input int bits);
        return (data_bits + bits - 1) / bits;
    endfunction

    // Offset between data bit 0 and its locator exponent.
    function automatic int bch_skip(input bch_params_t p);
        return p.data_bits - p.k + bch_n(p.m);
    endfunction

    function automatic int bch_pos_width(input int data_bits);
        return (data_bits > 1) ? $clog2(data_bits) : 1;
    endfunction

    // Primitive polynomials, including the x^m term.
    function automatic logic [c_gf_w-1:0] bch_prim_poly(input int m);
        case (m)
            2:       return 17'h00007;
            3:       return 17'h0000B;
            4:       return 17'h00013;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00089;
            8:       return 17'h0011D;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            15:      return 17'h08003;
            default: return 17'h1002D;
        endcase
    endfunction

    function automatic logic [c_gf_w-1:0] gf_mul_alpha(input int m, input logic [c_gf_w-1:0] x);
        logic [c_gf_w-1:0] r;
        r = x << 1;
        if ((r & (c_gf_w'(1) << m)) != '0)
            r = r ^ bch_prim_poly(m);
        return r;
    endfunction

    // Shift-and-add multiply; constant b folds to an XOR network.
    function automatic logic [c_gf_w-1:0] gf_mult(input int m, input logic [c_gf_w-1:0] a,
                                                  input logic [c_gf_w-1:0] b);
        logic [c_gf_w-1:0] r;
        r = '0;
        for (int i = m - 1; i >= 0; i--) begin
            r = gf_mul_alpha(m, r);
            if (((b >> i) & c_gf_w'(1)) != '0)
                r = r ^ a;
        end
        return r;
    endfunction

    // alpha^e, exponent taken modulo 2^m-1 (negative exponents allowed).
    function automatic logic [c_gf_w-1:0] lpow(input int m, input int e);
        logic [c_gf_w-1:0] r;
        int n;
        int k;
        n = bch_n(m);
        k = e % n;
        if (k < 0)
            k = k + n;
        r = c_gf_w'(1);
        for (int i = 0; i < k; i++)
            r = gf_mul_alpha(m, r);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch_error_one_tally.sv
`default_nettype none
// ============================================================================
//  Module      : bch_error_one_tally
//  Description : Hit counter, first-hit position encoder and end-of-frame
//                status latches for the sequenced one-error locator.
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_error_one_tally
    import bch_error_one_seq_pkg::*;
#(
    parameter int BITS      = 1,
    parameter int DATA_BITS = 1,
    parameter int POS_W     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sigma_nz,
    input  logic             valid,
    input  logic [BITS-1:0]  err,
    input  logic             done,
    output logic             err_found,
    output logic             fail,
    output logic [POS_W-1:0] err_pos
);

    localparam int c_windows = bch_windows(DATA_BITS, BITS);
    localparam int c_base_w  = $clog2(c_windows * BITS + 1);

    logic [1:0]          r_count;
    logic [c_base_w-1:0] r_base;
    logic [POS_W-1:0]    r_pos_run;
    logic [POS_W-1:0]    r_pos;
    logic                r_sigma_nz;
    logic                r_found;
    logic                r_fail;

    logic [BITS-1:0]     w_hits;
    logic [1:0]          w_count_next;
    logic [POS_W-1:0]    w_enc_pos;
    logic [POS_W-1:0]    w_pos_now;
    logic                w_found_now;
    logic                w_fail_now;
    int                  w_pop;
    int                  w_sum;
    int                  w_pos_int;

    // Count hits in the current window and encode the lowest hit position.
    always_comb begin
        w_hits    = valid ? err : '0;
        w_pop     = 0;
        w_pos_int = int'(r_base);
        for (int b = BITS - 1; b >= 0; b--) begin
            if (w_hits[b]) begin
                w_pop     = w_pop + 1;
                w_pos_int = int'(r_base) + b;
            end
        end
        w_sum        = int'(r_count) + w_pop;
        w_count_next = (w_sum > 3) ? 2'd3 : w_sum[1:0];
        w_enc_pos    = POS_W'(w_pos_int);
        // Only the first hit of a frame sets the position.
        w_pos_now    = (r_count == 2'd0 && w_hits != '0) ? w_enc_pos : r_pos_run;
        w_found_now  = (w_count_next == 2'd1);
        w_fail_now   = (r_sigma_nz && w_count_next == 2'd0) || (w_count_next >= 2'd2);
    end

    // Accumulate over valid windows; capture status on done, clear on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_base     <= '0;
            r_pos_run  <= '0;
            r_pos      <= '0;
            r_sigma_nz <= 1'b0;
            r_found    <= 1'b0;
            r_fail     <= 1'b0;
        end else if (start) begin
            r_count    <= '0;
            r_base     <= '0;
            r_pos_run  <= '0;
            r_pos      <= '0;
            r_sigma_nz <= sigma_nz;
            r_found    <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            if (valid) begin
                r_count   <= w_count_next;
                r_base    <= r_base + c_base_w'(BITS);
                r_pos_run <= w_pos_now;
            end
            if (done) begin
                r_found <= w_found_now;
                r_fail  <= w_fail_now;
                r_pos   <= w_found_now ? w_pos_now : '0;
            end
        end
    end

    // Status is live during the done cycle, held afterwards.
    assign err_found = done ? w_found_now : r_found;
    assign fail      = done ? w_fail_now  : r_fail;
    assign err_pos   = done ? (w_found_now ? w_pos_now : '0) : r_pos;

endmodule
`default_nettype wire

// File: rtl/bch_error_one_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bch_error_one_seq
//  Description : Sequenced single-error locator. Steps a reduced Chien
//                register over the data word BITS positions per cycle and
//                emits a per-window error mask plus end-of-frame status.
//  Revision    : 1.0 - initial release
// ============================================================================
module bch_error_one_seq
    import bch_error_one_seq_pkg::*;
#(
    parameter bch_params_t P               = BCH_SANE,
    parameter int          BITS            = 1,
    parameter int          PIPELINE_STAGES = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [2*P.m-1:0]                        sigma,
    output logic                                    busy,
    output logic                                    first,
    output logic                                    last,
    output logic                                    valid,
    output logic [BITS-1:0]                         err,
    output logic                                    done,
    output logic                                    err_found,
    output logic                                    fail,
    output logic [bch_pos_width(P.data_bits)-1:0]   err_pos
);

    localparam int c_m         = P.m;
    localparam int c_t         = P.t;
    localparam int c_data_bits = P.data_bits;
    localparam int c_windows   = bch_windows(c_data_bits, BITS);
    localparam int c_skip      = bch_skip(P);
    localparam int c_pos_w     = bch_pos_width(c_data_bits);
    localparam int c_win_w     = (c_windows > 1) ? $clog2(c_windows) : 1;
    localparam int c_pw        = BITS + 4;
    // The register walks the locator back one stride per cycle, so a fixed
    // comparator bank sees successive data positions.
    localparam logic [c_gf_w-1:0] c_step = lpow(c_m, -BITS);

    // Refuse unsupported configurations at elaboration.
    if (c_t < 2) begin : g_chk_sec
        $error("one_does_not_support_sec");
    end
    if (PIPELINE_STAGES < 0 || PIPELINE_STAGES > 4) begin : g_chk_stages
        $error("one_seq_max_4_pipeline_stages");
    end

    one_seq_state_t     r_state;
    one_seq_state_t     w_state_next;
    logic [c_m-1:0]     r_chien;
    logic [c_win_w-1:0] r_win;
    logic [c_win_w-1:0] w_win_next;
    logic [2:0]         r_flush;
    logic [2:0]         w_flush_next;
    logic [c_gf_w-1:0]  w_chien_step;
    logic [BITS-1:0]    w_raw;
    logic               w_run;
    logic               w_last_win;
    logic [c_pw-1:0]    w_stage_in;
    logic [c_pw-1:0]    r_pipe [0:PIPELINE_STAGES];
    logic               w_unused_sigma_lo;

    assign w_unused_sigma_lo = ^sigma[c_m-1:0];

    assign w_run      = (r_state == ST_RUN);
    assign w_last_win = (int'(r_win) == c_windows - 1);

    // Next state, window and flush counters.
    always_comb begin
        w_state_next = r_state;
        w_win_next   = r_win;
        w_flush_next = r_flush;
        if (start) begin
            w_state_next = ST_RUN;
            w_win_next   = '0;
            w_flush_next = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_last_win) begin
                        w_state_next = (PIPELINE_STAGES > 0) ? ST_FLUSH : ST_IDLE;
                        w_flush_next = '0;
                    end else begin
                        w_win_next = r_win + c_win_w'(1);
                    end
                end
                ST_FLUSH: begin
                    if (int'(r_flush) >= PIPELINE_STAGES - 1)
                        w_state_next = ST_IDLE;
                    else
                        w_flush_next = r_flush + 3'd1;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_win   <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_state_next;
            r_win   <= w_win_next;
            r_flush <= w_flush_next;
        end
    end

    assign w_chien_step = gf_mult(c_m, {{(c_gf_w - c_m){1'b0}}, r_chien}, c_step);

    // Chien register: load sigma1 on start, step once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_chien <= '0;
        else if (start)
            r_chien <= sigma[c_m +: c_m];
        else if (w_run)
            r_chien <= w_chien_step[c_m-1:0];
    end

    // One comparator per lane; positions past the data word never hit.
    for (genvar b = 0; b < BITS; b++) begin : g_cmp
        localparam logic [c_gf_w-1:0] c_root = lpow(c_m, c_skip + b);
        assign w_raw[b] = w_run && (r_chien == c_root[c_m-1:0])
                          && ((int'(r_win) * BITS + b) < c_data_bits);
    end

    assign w_stage_in = {w_run && w_last_win, w_run && w_last_win,
                         w_run && (r_win == '0), w_run, w_raw};

    // Output register plus PIPELINE_STAGES delays; start squashes in-flight windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPELINE_STAGES; i++)
                r_pipe[i] <= '0;
        end else if (start) begin
            for (int i = 0; i <= PIPELINE_STAGES; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i <= PIPELINE_STAGES; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {done, last, first, valid, err} = r_pipe[PIPELINE_STAGES];

    // Busy covers RUN, FLUSH and the final window leaving the pipeline.
    assign busy = (r_state != ST_IDLE) || valid;

    bch_error_one_tally #(
        .BITS      (BITS),
        .DATA_BITS (c_data_bits),
        .POS_W     (c_pos_w)
    ) u_tally (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sigma_nz  (sigma[c_m +: c_m] != '0),
        .valid     (valid),
        .err       (err),
        .done      (done),
        .err_found (err_found),
        .fail      (fail),
        .err_pos   (err_pos)
    );

endmodule
`default_nettype wire
